// File: rtl/toggle_pkg.sv
// toggle_pkg: shared FSM state encoding and default counter width for the toggle event decoder.
`default_nettype none

package toggle_pkg;

   localparam int CNT_W_DEFAULT = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      FULL = 2'd2
   } state_t;

endpackage

`default_nettype wire

// File: rtl/toggle_sync.sv
// toggle_sync: 1-bit, 2-stage synchronizer; reset preloads both stages with the input level.
`default_nettype none

module toggle_sync (
   input  logic clk,
   input  logic rst,
   input  logic i_d,
   output logic o_q
);

   logic r_s1;
   logic r_s2;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1 <= i_d;
         r_s2 <= i_d;
      end else begin
         r_s1 <= i_d;
         r_s2 <= r_s1;
      end
   end

   assign o_q = r_s2;

endmodule

`default_nettype wire

// File: rtl/toggle_event_decoder.sv
// toggle_event_decoder: turns TGL level changes into pulses and a saturating pending-event queue.
// Optional input synchronizer enabled by macro TOGGLE_SYNC_EN.
`default_nettype none

module toggle_event_decoder
   import toggle_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEFAULT
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             TGL,
   input  logic             EVT_READY,
   input  logic             OVF_CLR,
   output logic             PULSE,
   output logic             LEVEL,
   output logic             EVT_VALID,
   output logic [CNT_W-1:0] EVT_PENDING,
   output logic             OVF
);

   localparam logic [CNT_W-1:0] c_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] c_MAX = {CNT_W{1'b1}};

   logic             w_tgl_in;
   logic             r_tgl_s;
   logic             r_level;
   logic             r_pulse;
   logic             r_ovf;
   logic [CNT_W-1:0] r_pending;
   state_t           r_state;

   logic             w_event;
   logic             w_accept;
   logic             w_ovf_set;
   logic [CNT_W-1:0] w_pending_nxt;

`ifdef TOGGLE_SYNC_EN
   toggle_sync u_sync (
      .clk (CLK),
      .rst (RST),
      .i_d (TGL),
      .o_q (w_tgl_in)
   );
`else
   assign w_tgl_in = TGL;
`endif

   assign w_event  = (r_tgl_s != r_level);
   assign w_accept = (r_state != IDLE) && EVT_READY;

   // Event and accept in the same cycle cancel; a saturated count drops the event instead of wrapping.
   always_comb begin
      w_pending_nxt = r_pending;
      w_ovf_set     = 1'b0;
      if (w_event && !w_accept) begin
         if (r_state == FULL) begin
            w_ovf_set = 1'b1;
         end else begin
            w_pending_nxt = r_pending + c_ONE;
         end
      end else if (!w_event && w_accept) begin
         w_pending_nxt = r_pending - c_ONE;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_tgl_s   <= TGL;
         r_level   <= TGL;
         r_pulse   <= 1'b0;
         r_ovf     <= 1'b0;
         r_pending <= '0;
         r_state   <= IDLE;
      end else begin
         r_tgl_s   <= w_tgl_in;
         r_level   <= r_tgl_s;
         r_pulse   <= w_event;
         r_ovf     <= w_ovf_set | (r_ovf & ~OVF_CLR);
         r_pending <= w_pending_nxt;
         if (w_pending_nxt == '0) begin
            r_state <= IDLE;
         end else if (w_pending_nxt == c_MAX) begin
            r_state <= FULL;
         end else begin
            r_state <= BUSY;
         end
      end
   end

   assign PULSE       = r_pulse;
   assign LEVEL       = r_level;
   assign EVT_VALID   = (r_state != IDLE);
   assign EVT_PENDING = r_pending;
   assign OVF         = r_ovf;

endmodule

`default_nettype wire

// File: doc/toggle_event_decoder.md
TOGGLE_EVENT_DECODER -- requirements
Module: toggle_event_decoder

Interface
REQ-001 SHALL have parameter CNT_W, default 4, width of the pending-event counter.
REQ-002 SHALL have port CLK  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port RST  input  1  reset; one clock, reset is synchronous and active-high.
REQ-004 SHALL have port TGL  input  1  toggle line driven by a T flip-flop style source; each level change is one event.
REQ-005 SHALL have port EVT_READY  input  1  consumer accepts one pending event this cycle.
REQ-006 SHALL have port OVF_CLR  input  1  clears the sticky overflow flag.
REQ-007 SHALL have port PULSE  output  1  one-cycle pulse per detected TGL change.
REQ-008 SHALL have port LEVEL  output  1  registered copy of the sampled TGL level.
REQ-009 SHALL have port EVT_VALID  output  1  high while at least one event is pending.
REQ-010 SHALL have port EVT_PENDING  output  CNT_W  number of unaccepted events.
REQ-011 SHALL have port OVF  output  1  sticky flag: an event was lost at saturation.

Function
REQ-012 SHALL sample TGL into register tgl_s each cycle; an event is tgl_s != LEVEL, after which LEVEL takes tgl_s.
REQ-013 SHALL assert PULSE for exactly the cycle after the sampled change (latency 2 cycles from TGL change to PULSE with sync disabled).
REQ-014 SHALL detect back-to-back toggles (TGL changing every cycle) as one event per cycle, without merging.
REQ-015 SHALL drive EVT_VALID = (EVT_PENDING != 0), registered-derived, with no combinational path from EVT_READY.
REQ-016 SHALL accept when EVT_VALID && EVT_READY; EVT_READY with EVT_VALID low is ignored.
REQ-017 SHALL update pending: event only -> +1; accept only -> -1; event and accept together -> unchanged.
REQ-018 SHALL saturate EVT_PENDING at 2^CNT_W-1; event at saturation without accept -> count held, OVF set next cycle.
REQ-019 SHALL implement FSM IDLE (pending 0), BUSY (1..max-1), FULL (max); transitions follow REQ-017/018; FULL + accept -> BUSY; BUSY with pending 1 + accept and no event -> IDLE.
REQ-020 SHALL clear OVF on OVF_CLR; OVF_CLR and a new overflow in the same cycle -> OVF stays 1.
REQ-021 SHALL not wrap EVT_PENDING in either direction under any input sequence.

Reset
REQ-022 SHALL, while RST is high, force PULSE=0, EVT_VALID=0, EVT_PENDING=0, OVF=0, FSM=IDLE.
REQ-023 SHALL, during reset, load LEVEL and tgl_s (and sync stages) from current TGL, so a steady TGL=1 at reset release yields no event.
REQ-024 SHALL discard pending events and an in-flight PULSE when RST asserts mid-operation; first event after release counts from 0.

Configuration
REQ-025 SHALL honour macro TOGGLE_SYNC_EN: when defined, TGL passes a 2-flop synchronizer before tgl_s, adding 2 cycles (PULSE latency 4); when undefined, TGL feeds tgl_s directly (latency 2).
REQ-026 SHALL keep all other behaviour, ports and reset values identical in both builds.

Structure
REQ-027 SHALL place FSM state typedef (IDLE/BUSY/FULL) and default CNT_W constant in shared package toggle_pkg.
REQ-028 SHALL implement the synchronizer as sub-module toggle_sync (1-bit, 2 stages, reset loads input value), instantiated only under TOGGLE_SYNC_EN.

Verification
REQ-029 SHALL cover: RST high 3 cycles with TGL=1, release, hold TGL=1 10 cycles -> PULSE never high, EVT_PENDING=0.
REQ-030 SHALL cover: TGL 0->1, EVT_READY=0 -> PULSE high 1 cycle at latency 2 (4 with sync), EVT_PENDING=1, EVT_VALID=1.
REQ-031 SHALL cover: TGL toggling every cycle 5 times, EVT_READY=0 -> 5 PULSE cycles, EVT_PENDING=5.
REQ-032 SHALL cover: CNT_W=4, 17 events without accept -> EVT_PENDING=15, FSM FULL, OVF=1; OVF_CLR 1 cycle -> OVF=0, pending still 15.
REQ-033 SHALL cover: pending=3, event and EVT_READY same cycle -> pending stays 3; then EVT_READY 3 cycles -> pending 0, EVT_VALID=0, FSM IDLE.
REQ-034 SHALL cover: pending=6, RST pulsed 1 cycle mid-stream -> next cycle EVT_PENDING=0, OVF=0, PULSE=0.
